// File: rtl/pcileech_ft601_gate_if.sv
// FT601 signal bundle around the DNA gate: controller-side (com_*) and
// pad-side (ft601_*) strobes and flags. The gate uses the slave view; the
// controller plus physical pads together form the master view.
interface pcileech_ft601_gate_if;
  logic com_wr_n;
  logic com_rd_n;
  logic com_oe_n;
  logic com_siwu_n;
  logic com_rst_n;
  logic com_rxf_n;
  logic com_txe_n;
  logic ft601_rxf_n;
  logic ft601_txe_n;
  logic ft601_wr_n;
  logic ft601_rd_n;
  logic ft601_oe_n;
  logic ft601_siwu_n;
  logic ft601_rst_n;

  modport master (
    output com_wr_n, com_rd_n, com_oe_n, com_siwu_n, com_rst_n,
    output ft601_rxf_n, ft601_txe_n,
    input  com_rxf_n, com_txe_n,
    input  ft601_wr_n, ft601_rd_n, ft601_oe_n, ft601_siwu_n, ft601_rst_n
  );

  modport slave (
    input  com_wr_n, com_rd_n, com_oe_n, com_siwu_n, com_rst_n,
    input  ft601_rxf_n, ft601_txe_n,
    output com_rxf_n, com_txe_n,
    output ft601_wr_n, ft601_rd_n, ft601_oe_n, ft601_siwu_n, ft601_rst_n
  );
endinterface

// File: rtl/pcileech_ft601_gate.sv
// Enforcement gate for the device-DNA check. FT601 traffic passes only after
// a valid, matching DNA result. A mismatch, a dropped result or a missing
// result within the timeout leads (via an orderly drain of any in-flight bus
// cycle) to a sticky lock that only rst_n clears.
module pcileech_ft601_gate #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000,
  parameter logic [15:0] DRAIN_CYCLES   = 16'd1024,
  parameter logic [4:0]  BLINK_LOG2     = 5'd24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dna_valid,
  input  logic                      id_match,
  pcileech_ft601_gate_if.slave      bus,
  output logic [1:0]                gate_state,
  output logic                      led_lock
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  localparam logic [BLINK_LOG2:0] BLINK_ONE = {{BLINK_LOG2{1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_s;
  logic [31:0]         timeout_cnt_r;
  logic [31:0]         timeout_cnt_s;
  logic [15:0]         drain_cnt_r;
  logic [15:0]         drain_cnt_s;
  logic [BLINK_LOG2:0] blink_cnt_r;
  logic [BLINK_LOG2:0] blink_cnt_s;
  logic                bus_idle_s;

  assign bus_idle_s = bus.com_wr_n & bus.com_rd_n & bus.com_oe_n;

  // State and counter registers; asynchronous clear back to WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_WAIT;
      timeout_cnt_r <= 32'd0;
      drain_cnt_r   <= 16'd0;
      blink_cnt_r   <= {(BLINK_LOG2 + 5'd1){1'b0}};
    end else begin
      state_r       <= state_s;
      timeout_cnt_r <= timeout_cnt_s;
      drain_cnt_r   <= drain_cnt_s;
      blink_cnt_r   <= blink_cnt_s;
    end
  end

  // Next-state and counter logic. id_match is only looked at once dna_valid
  // is high so an undriven comparator output cannot steer the FSM.
  always_comb begin
    state_s       = state_r;
    timeout_cnt_s = timeout_cnt_r;
    drain_cnt_s   = 16'd0;
    blink_cnt_s   = blink_cnt_r;
    case (state_r)
      ST_WAIT: begin
        // Saturating count so a held-off result can never re-enter timing.
        if (timeout_cnt_r < (TIMEOUT_CYCLES - 32'd1)) begin
          timeout_cnt_s = timeout_cnt_r + 32'd1;
        end else begin
          timeout_cnt_s = timeout_cnt_r;
        end
        if (dna_valid) begin
          if (id_match) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_LOCK;
          end
        end else if (timeout_cnt_r >= (TIMEOUT_CYCLES - 32'd1)) begin
          state_s = ST_LOCK;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RUN: begin
        if (dna_valid && id_match) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A recovered id_match is deliberately not a way back to RUN.
        if (bus_idle_s) begin
          state_s = ST_LOCK;
        end else if (drain_cnt_r >= (DRAIN_CYCLES - 16'd1)) begin
          state_s = ST_LOCK;
        end else begin
          state_s     = ST_DRAIN;
          drain_cnt_s = drain_cnt_r + 16'd1;
        end
      end
      ST_LOCK: begin
        state_s     = ST_LOCK;
        blink_cnt_s = blink_cnt_r + BLINK_ONE;
      end
      default: begin
        state_s = ST_LOCK;
      end
    endcase
  end

  // Pad/flag muxes selected by the registered state (no added latency).
  always_comb begin
    bus.ft601_wr_n   = 1'b1;
    bus.ft601_rd_n   = 1'b1;
    bus.ft601_oe_n   = 1'b1;
    bus.ft601_siwu_n = 1'b1;
    bus.ft601_rst_n  = 1'b0;
    bus.com_rxf_n    = 1'b1;
    bus.com_txe_n    = 1'b1;
    case (state_r)
      ST_RUN: begin
        bus.ft601_wr_n   = bus.com_wr_n;
        bus.ft601_rd_n   = bus.com_rd_n;
        bus.ft601_oe_n   = bus.com_oe_n;
        bus.ft601_siwu_n = bus.com_siwu_n;
        bus.ft601_rst_n  = bus.com_rst_n;
        bus.com_rxf_n    = bus.ft601_rxf_n;
        bus.com_txe_n    = bus.ft601_txe_n;
      end
      ST_DRAIN: begin
        // Finish the current cycle, but advertise no data/space so the
        // controller cannot start another one.
        bus.ft601_wr_n   = bus.com_wr_n;
        bus.ft601_rd_n   = bus.com_rd_n;
        bus.ft601_oe_n   = bus.com_oe_n;
        bus.ft601_siwu_n = bus.com_siwu_n;
        bus.ft601_rst_n  = bus.com_rst_n;
        bus.com_rxf_n    = 1'b1;
        bus.com_txe_n    = 1'b1;
      end
      default: begin
        bus.ft601_wr_n   = 1'b1;
        bus.ft601_rd_n   = 1'b1;
        bus.ft601_oe_n   = 1'b1;
        bus.ft601_siwu_n = 1'b1;
        bus.ft601_rst_n  = 1'b0;
        bus.com_rxf_n    = 1'b1;
        bus.com_txe_n    = 1'b1;
      end
    endcase
  end

  assign gate_state = state_r;
  // The blink counter only runs in LOCK, so its top bit is 0 everywhere else.
  assign led_lock   = blink_cnt_r[BLINK_LOG2];

endmodule

// File: tb/tb_pcileech_ft601_gate.sv
// Directed bench for pcileech_ft601_gate with short timeout/drain/blink
// parameters so every boundary is reachable in a few hundred cycles.
module tb_pcileech_ft601_gate;

  logic       clk;
  logic       rst_n;
  logic       dna_valid;
  logic       id_match;
  logic [1:0] gate_state;
  logic       led_lock;
  int         tests;
  int         fails;

  pcileech_ft601_gate_if bus ();

  pcileech_ft601_gate #(
    .TIMEOUT_CYCLES (32'd50),
    .DRAIN_CYCLES   (16'd16),
    .BLINK_LOG2     (5'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dna_valid  (dna_valid),
    .id_match   (id_match),
    .bus        (bus.slave),
    .gate_state (gate_state),
    .led_lock   (led_lock)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then step 1 unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    dna_valid = 1'b0;
    id_match = 1'b0;
    bus.com_wr_n = 1'b0;
    bus.com_rd_n = 1'b1;
    bus.com_oe_n = 1'b1;
    bus.com_siwu_n = 1'b1;
    bus.com_rst_n = 1'b1;
    bus.ft601_rxf_n = 1'b0;
    bus.ft601_txe_n = 1'b0;

    // Held in reset for 100 cycles: pads idle, flags blocked.
    tick(100);
    check("rst_state", 32'(gate_state), 32'd0);
    check("rst_wr_n", 32'(bus.ft601_wr_n), 32'd1);
    check("rst_pad_rst_n", 32'(bus.ft601_rst_n), 32'd0);
    check("rst_com_txe_n", 32'(bus.com_txe_n), 32'd1);
    check("rst_com_rxf_n", 32'(bus.com_rxf_n), 32'd1);
    check("rst_led", 32'(led_lock), 32'd0);

    // Release; DNA result arrives at cycle 10 -> RUN on the next edge.
    bus.com_wr_n = 1'b1;
    rst_n = 1'b1;
    tick(10);
    check("wait_c10_state", 32'(gate_state), 32'd0);
    dna_valid = 1'b1;
    id_match = 1'b1;
    tick(1);
    check("run_state", 32'(gate_state), 32'd1);
    bus.com_wr_n = 1'b0;
    #1;
    check("run_wr_low", 32'(bus.ft601_wr_n), 32'd0);
    bus.com_wr_n = 1'b1;
    #1;
    check("run_wr_high", 32'(bus.ft601_wr_n), 32'd1);
    check("run_txe_pass", 32'(bus.com_txe_n), 32'd0);
    check("run_rxf_pass", 32'(bus.com_rxf_n), 32'd0);
    check("run_rst_pass", 32'(bus.ft601_rst_n), 32'd1);
    bus.com_siwu_n = 1'b0;
    #1;
    check("run_siwu_pass", 32'(bus.ft601_siwu_n), 32'd0);
    bus.com_siwu_n = 1'b1;

    // Read in flight, id_match drops -> DRAIN; flags blocked, strobes pass.
    bus.com_rd_n = 1'b0;
    bus.com_oe_n = 1'b0;
    id_match = 1'b0;
    tick(1);
    check("drain_state", 32'(gate_state), 32'd2);
    check("drain_rxf_blk", 32'(bus.com_rxf_n), 32'd1);
    check("drain_txe_blk", 32'(bus.com_txe_n), 32'd1);
    check("drain_rd_pass", 32'(bus.ft601_rd_n), 32'd0);
    id_match = 1'b1;
    tick(6);
    check("drain_hold", 32'(gate_state), 32'd2);
    bus.com_rd_n = 1'b1;
    bus.com_oe_n = 1'b1;
    tick(1);
    check("drain_to_lock", 32'(gate_state), 32'd3);
    check("lock_rd_n", 32'(bus.ft601_rd_n), 32'd1);
    bus.com_rd_n = 1'b0;
    #1;
    check("lock_rd_forced", 32'(bus.ft601_rd_n), 32'd1);
    check("lock_pad_rst", 32'(bus.ft601_rst_n), 32'd0);
    check("lock_txe_blk", 32'(bus.com_txe_n), 32'd1);
    bus.com_rd_n = 1'b1;

    // Blink: bit 2 of a counter started on LOCK entry.
    tick(3);
    check("blink_c3", 32'(led_lock), 32'd0);
    tick(1);
    check("blink_c4", 32'(led_lock), 32'd1);
    tick(4);
    check("blink_c8", 32'(led_lock), 32'd0);
    check("lock_sticky", 32'(gate_state), 32'd3);

    // Asynchronous reset pulse with no clock edge.
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(gate_state), 32'd0);
    check("async_rst_led", 32'(led_lock), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("rerun_state", 32'(gate_state), 32'd1);

    // Write stuck low while dna_valid drops -> drain times out after 16.
    bus.com_wr_n = 1'b0;
    dna_valid = 1'b0;
    tick(1);
    check("drain2_state", 32'(gate_state), 32'd2);
    tick(15);
    check("drain2_c15", 32'(gate_state), 32'd2);
    tick(1);
    check("drain2_timeout", 32'(gate_state), 32'd3);
    check("drain2_wr_forced", 32'(bus.ft601_wr_n), 32'd1);
    bus.com_wr_n = 1'b1;

    // No DNA result: LOCK after exactly 50 cycles; id_match ignored.
    pulse_reset();
    tick(49);
    check("to_c49", 32'(gate_state), 32'd0);
    tick(1);
    check("to_c50", 32'(gate_state), 32'd3);
    tick(4);
    check("to_blink", 32'(led_lock), 32'd1);

    // dna_valid in the timeout cycle wins.
    pulse_reset();
    tick(49);
    dna_valid = 1'b1;
    id_match = 1'b1;
    tick(1);
    check("race_run", 32'(gate_state), 32'd1);

    // Mismatching result in WAIT locks directly.
    dna_valid = 1'b0;
    pulse_reset();
    tick(3);
    dna_valid = 1'b1;
    id_match = 1'b0;
    tick(1);
    check("mismatch_lock", 32'(gate_state), 32'd3);
    check("mismatch_siwu", 32'(bus.ft601_siwu_n), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
